noc_gpu_port: RTL and testbench
===============================

Name: noc_gpu_port

Overview:
- Network-side attachment point for one GPU node's 16-bit flit interface. It sits directly between the GPU's net_* pins and a NoC router link.
- TX path: buffers single-cycle flit pulses from the GPU in a FIFO and forwards them on a valid/ready link.
- RX path: takes flits from the link, filters them by destination ID, and delivers matching flits to the GPU as single-cycle pulses. Each delivery is followed by a mandatory gap cycle.
- Flit format: [15:10] destination GPU ID, [9:0] payload.

Parameters:
- LOCAL_ID, 28: GPU ID served by this port; compared against flit bits [15:10].
- TX_DEPTH, 8: TX FIFO entries; power of two, >= 4.
- CNT_W, 16: width of statistics counters.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- gpu_tx_data  in  16  flit from GPU (GPU net_data_out)
- gpu_tx_valid  in  1  single-cycle flit strobe (GPU net_valid_out)
- gpu_tx_ready  out  1  space available; registered (to GPU net_ready_in)
- gpu_rx_data  out  16  flit to GPU (GPU net_data_in)
- gpu_rx_valid  out  1  single-cycle delivery strobe (GPU net_valid_in)
- gpu_rx_ready  in  1  GPU able to receive (GPU net_ready_out)
- link_tx_data  out  16  flit toward router
- link_tx_valid  out  1  TX FIFO non-empty
- link_tx_ready  in  1  router accepts
- link_rx_data  in  16  flit from router
- link_rx_valid  in  1  router offers flit
- link_rx_ready  out  1  port accepts flit
- tx_level  out  log2(TX_DEPTH)+1  TX FIFO occupancy
- tx_overflow  out  1  sticky: a GPU flit was dropped on full FIFO
- tx_cnt, rx_cnt, drop_cnt  out  CNT_W each  statistics (see Optional Feature)

Behaviour:
- Reset (ARESETn low, async): FIFO emptied; tx_level=0, tx_overflow=0, gpu_tx_ready=0, gpu_rx_valid=0, gpu_rx_data=0, link_tx_valid=0, link_rx_ready=0, all counters=0, RX state=RX_IDLE.
- Reset asserted mid-operation discards buffered and held flits; nothing is replayed.
- TX push:
  - gpu_tx_valid is a pulse and is not qualified by gpu_tx_ready. Every pulse writes the FIFO unless the FIFO is full after this cycle's pop.
  - If full: the flit is dropped and tx_overflow set. tx_overflow clears only on reset.
- TX ready:
  - gpu_tx_ready is registered: 1 when next-cycle occupancy <= TX_DEPTH-2.
  - This leaves one skid entry, because the GPU samples ready one cycle before it strobes.
  - First cycle after reset release: gpu_tx_ready=1.
- TX pop:
  - FIFO is first-word-fall-through: link_tx_data = head, link_tx_valid = (level != 0), combinational from FIFO state.
  - Pop on link_tx_valid & link_tx_ready.
  - Simultaneous push and pop: level unchanged; a push on a full FIFO with a same-cycle pop is accepted.
  - Pointers wrap modulo TX_DEPTH. Order is strictly FIFO.
- TX latency: GPU strobe at cycle N -> link_tx_valid at N+1 (FIFO previously empty).
- RX FSM states RX_IDLE, RX_WAIT, RX_PRESENT, RX_GAP. link_rx_ready = (state == RX_IDLE), registered.
  - RX_IDLE: on link_rx_valid & link_rx_ready, capture flit.
    - If flit[15:10] == LOCAL_ID: go to RX_WAIT.
    - Otherwise: drop the flit, drop_cnt++, stay in RX_IDLE (ready held high, back-to-back drops allowed).
  - RX_WAIT: if gpu_rx_ready=1, go to RX_PRESENT with gpu_rx_data = held flit and gpu_rx_valid=1 registered. Otherwise wait indefinitely.
  - RX_PRESENT: lasts exactly one cycle; gpu_rx_valid returns to 0; go to RX_GAP.
  - RX_GAP: one idle cycle (covers the GPU's one-cycle ready drop); go to RX_IDLE.
  - gpu_rx_data holds its last value outside RX_PRESENT.
- RX latency: link accept at N -> gpu_rx_valid at N+2 (gpu_rx_ready high). Minimum 4 cycles per delivered flit.
- Counters saturate at all-ones; no wrap.
  - tx_cnt increments per flit popped to the link.
  - rx_cnt increments per flit delivered to the GPU.

Optional Feature:
- Macro NOC_GPU_PORT_STATS_EN.
- Defined: tx_cnt, rx_cnt and drop_cnt are implemented as above.
- Undefined: the counter registers are not built; the three outputs are tied to 0.
- Filtering, dropping and tx_overflow behave identically either way.

Test Plan:
- Reset release, idle link -> gpu_tx_ready=1 one cycle after release; link_tx_valid=0; link_rx_ready=1; gpu_rx_valid=0.
- GPU pulse 16'h7523 (dest 29, payload 0x123), link_tx_ready=1 -> link_tx_data=16'h7523, link_tx_valid for one cycle; tx_level 1 then 0; tx_cnt=1.
- link_tx_ready=0, 9 pulses (DEPTH 8) -> gpu_tx_ready=0 at level 7; 8 flits stored; 9th dropped; tx_overflow=1. Then release ready -> the 8 flits emerge in order.
- link_rx flit 16'h7001 (dest 28), gpu_rx_ready=1 -> gpu_rx_valid one cycle at accept+2 with data 16'h7001; link_rx_ready low for 3 cycles; rx_cnt=1.
- link_rx flits 16'h7401, 16'h7802 back-to-back (dest 29, 30) -> both accepted on consecutive cycles; no gpu_rx_valid; drop_cnt=2.
- Matching flit held with gpu_rx_ready=0 for 10 cycles, then 1 -> no delivery until ready; gpu_rx_valid one cycle later. Reset during RX_WAIT -> flit discarded, no delivery after release.

Source files
------------

// File: rtl/noc_gpu_port.sv
// noc_gpu_port: attaches one GPU node's 16-bit flit pins to a NoC router link.
//   TX: GPU flit pulses -> FWFT FIFO -> valid/ready link (one skid entry kept free).
//   RX: link flits filtered on dest ID [15:10]; matches delivered to the GPU as
//       one-cycle pulses, each followed by a mandatory gap cycle.
// Optional: define NOC_GPU_PORT_STATS_EN to build the tx/rx/drop counters;
// without it the three counter outputs are tied to zero.
// Link handshake: a flit moves on a cycle where valid and ready are both high;
// the sender holds data stable while valid is high and ready is low.
module noc_gpu_port #(
    parameter int LOCAL_ID = 28,
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = 16,
    localparam int LVL_W   = $clog2(TX_DEPTH) + 1,
    localparam int PTR_W   = $clog2(TX_DEPTH)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [15:0]      gpu_tx_data,
    input  logic             gpu_tx_valid,
    output logic             gpu_tx_ready,
    output logic [15:0]      gpu_rx_data,
    output logic             gpu_rx_valid,
    input  logic             gpu_rx_ready,
    output logic [15:0]      link_tx_data,
    output logic             link_tx_valid,
    input  logic             link_tx_ready,
    input  logic [15:0]      link_rx_data,
    input  logic             link_rx_valid,
    output logic             link_rx_ready,
    output logic [LVL_W-1:0] tx_level,
    output logic             tx_overflow,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [1:0]       rx_state_dbg
);

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_WAIT    = 2'd1,
        RX_PRESENT = 2'd2,
        RX_GAP     = 2'd3
    } rx_state_e;

    // ---------------- TX FIFO ----------------
    logic [15:0]      mem_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             tx_ready_q, tx_ready_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, full_after_pop;

    assign pop            = (level_q != '0) & link_tx_ready;
    assign full_after_pop = (level_q == LVL_W'(TX_DEPTH)) & ~pop;
    assign push           = gpu_tx_valid & ~full_after_pop;
    assign level_d        = level_q + LVL_W'(push) - LVL_W'(pop);
    // Ready is registered one cycle ahead of the GPU's strobe, so keep one skid slot.
    assign tx_ready_d     = (level_d <= LVL_W'(TX_DEPTH - 2));
    assign ovf_d          = ovf_q | (gpu_tx_valid & full_after_pop);

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= gpu_tx_data;
    end

    // FIFO pointers, occupancy, registered ready and sticky overflow.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_ready_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q    <= level_d;
            tx_ready_q <= tx_ready_d;
            ovf_q      <= ovf_d;
        end
    end

    assign link_tx_data  = mem_q[rd_ptr_q];
    assign link_tx_valid = (level_q != '0);
    assign tx_level      = level_q;
    assign gpu_tx_ready  = tx_ready_q;
    assign tx_overflow   = ovf_q;

    // ---------------- RX filter / delivery FSM ----------------
    rx_state_e   state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ready_q, rx_ready_d;
    logic        dest_match;

    assign dest_match = (link_rx_data[15:10] == 6'(LOCAL_ID));

    // Next-state and next-output logic for the RX path.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rx_data_d = rx_data_q;
        unique case (state_q)
            RX_IDLE: begin
                if (link_rx_valid && rx_ready_q && dest_match) begin
                    hold_d  = link_rx_data;
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (gpu_rx_ready) begin
                    rx_data_d = hold_q;
                    state_d   = RX_PRESENT;
                end
            end
            RX_PRESENT: state_d = RX_GAP;
            RX_GAP:     state_d = RX_IDLE;
            default:    state_d = RX_IDLE;
        endcase
        rx_valid_d = (state_d == RX_PRESENT);
        rx_ready_d = (state_d == RX_IDLE);
    end

    // RX state register and registered GPU/link outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= RX_IDLE;
            hold_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign gpu_rx_data   = rx_data_q;
    assign gpu_rx_valid  = rx_valid_q;
    assign link_rx_ready = rx_ready_q;
    assign rx_state_dbg  = state_q;

    // ---------------- Statistics ----------------
`ifdef NOC_GPU_PORT_STATS_EN
    logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;
    logic             deliver, drop_evt;

    assign deliver  = (state_q == RX_WAIT) & gpu_rx_ready;
    assign drop_evt = (state_q == RX_IDLE) & link_rx_valid & rx_ready_q & ~dest_match;

    // Saturating event counters.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop && !(&tx_cnt_q))        tx_cnt_q   <= tx_cnt_q + CNT_W'(1);
            if (deliver && !(&rx_cnt_q))    rx_cnt_q   <= rx_cnt_q + CNT_W'(1);
            if (drop_evt && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign tx_cnt   = tx_cnt_q;
    assign rx_cnt   = rx_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign tx_cnt   = '0;
    assign rx_cnt   = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_gpu_port.sv
// tb_noc_gpu_port: directed scenarios plus randomized traffic against a
// queue-based reference model of the port.
module tb_noc_gpu_port;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int LOCAL   = 28;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic ACLK;
  logic ARESETn;
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [15:0]      gpu_tx_data, gpu_rx_data, link_tx_data, link_rx_data;
  logic             gpu_tx_valid, gpu_tx_ready, gpu_rx_valid, gpu_rx_ready;
  logic             link_tx_valid, link_tx_ready, link_rx_valid, link_rx_ready;
  logic [LVL_W-1:0] tx_level;
  logic             tx_overflow;
  logic [CNT_W-1:0] tx_cnt, rx_cnt, drop_cnt;
  logic [1:0]       rx_state_dbg;

  noc_gpu_port #(.LOCAL_ID(LOCAL), .TX_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .gpu_tx_data   (gpu_tx_data),
    .gpu_tx_valid  (gpu_tx_valid),
    .gpu_tx_ready  (gpu_tx_ready),
    .gpu_rx_data   (gpu_rx_data),
    .gpu_rx_valid  (gpu_rx_valid),
    .gpu_rx_ready  (gpu_rx_ready),
    .link_tx_data  (link_tx_data),
    .link_tx_valid (link_tx_valid),
    .link_tx_ready (link_tx_ready),
    .link_rx_data  (link_rx_data),
    .link_rx_valid (link_rx_valid),
    .link_rx_ready (link_rx_ready),
    .tx_level      (tx_level),
    .tx_overflow   (tx_overflow),
    .tx_cnt        (tx_cnt),
    .rx_cnt        (rx_cnt),
    .drop_cnt      (drop_cnt),
    .rx_state_dbg  (rx_state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks;
  int n_fail;

  logic [15:0] exp_q[$];   // flits expected on the link, oldest first
  bit          m_tx_ready, m_ovf;
  int          m_tx_cnt, m_rx_cnt, m_drop_cnt;
  bit          m_rx_ready, m_rx_valid;
  logic [15:0] m_rx_data;
  bit          hold_v;     // a matching flit is waiting for the GPU
  logic [15:0] hold_flit;
  int          blocked;    // cycles until the link may be accepted again after a delivery

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_tx_ready = 0; m_ovf = 0;
    m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
    m_rx_ready = 0; m_rx_valid = 0; m_rx_data = '0;
    hold_v = 0; hold_flit = '0; blocked = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit deliver, accept;
    if (exp_q.size() != 0 && link_tx_ready) begin
      void'(exp_q.pop_front());
      m_tx_cnt = sat_inc(m_tx_cnt);
    end
    if (gpu_tx_valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(gpu_tx_data);
      else m_ovf = 1;
    end
    m_tx_ready = (exp_q.size() <= DEPTH - 2);

    deliver = hold_v && gpu_rx_ready;
    accept  = link_rx_valid && m_rx_ready;
    m_rx_valid = deliver;
    if (deliver) begin
      m_rx_data = hold_flit;
      hold_v    = 0;
      blocked   = 2;
      m_rx_cnt  = sat_inc(m_rx_cnt);
    end else if (blocked > 0) begin
      blocked--;
    end
    if (accept) begin
      if (int'(link_rx_data[15:10]) == LOCAL) begin
        hold_v    = 1;
        hold_flit = link_rx_data;
      end else begin
        m_drop_cnt = sat_inc(m_drop_cnt);
      end
    end
    m_rx_ready = !hold_v && (blocked == 0);
  endtask

  task automatic check_outputs();
    check("tx_level", 32'(tx_level), 32'(exp_q.size()));
    check("link_tx_valid", 32'(link_tx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("link_tx_data", 32'(link_tx_data), 32'(exp_q[0]));
    check("gpu_tx_ready", 32'(gpu_tx_ready), 32'(m_tx_ready));
    check("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    check("link_rx_ready", 32'(link_rx_ready), 32'(m_rx_ready));
    check("gpu_rx_valid", 32'(gpu_rx_valid), 32'(m_rx_valid));
    check("gpu_rx_data", 32'(gpu_rx_data), 32'(m_rx_data));
`ifdef NOC_GPU_PORT_STATS_EN
    check("tx_cnt", 32'(tx_cnt), 32'(m_tx_cnt));
    check("rx_cnt", 32'(rx_cnt), 32'(m_rx_cnt));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
`else
    check("tx_cnt", 32'(tx_cnt), 32'd0);
    check("rx_cnt", 32'(rx_cnt), 32'd0);
    check("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input logic tv, input logic [15:0] td, input logic ltr,
                      input logic lrv, input logic [15:0] lrd, input logic grr);
    gpu_tx_valid  = tv;
    gpu_tx_data   = td;
    link_tx_ready = ltr;
    link_rx_valid = lrv;
    link_rx_data  = lrd;
    gpu_rx_ready  = grr;
    model_step();
    @(posedge ACLK);
    @(negedge ACLK);
    check_outputs();
  endtask

  task automatic idle(input logic ltr, input logic grr);
    step(1'b0, 16'h0, ltr, 1'b0, 16'h0, grr);
  endtask

  task automatic do_reset();
    gpu_tx_valid = 0; link_rx_valid = 0;
    ARESETn = 1'b0;
    #1;
    model_reset();
    check_outputs();            // asynchronous clear is visible immediately
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    ARESETn = 1'b0;
    gpu_tx_valid = 0; gpu_tx_data = '0; link_tx_ready = 0;
    link_rx_valid = 0; link_rx_data = '0; gpu_rx_ready = 0;
    model_reset();
    repeat (2) @(negedge ACLK);
    check_outputs();
    ARESETn = 1'b1;
    check_outputs();

    // First cycle after release: TX ready and RX ready rise.
    idle(1'b1, 1'b1);
    check("rst_gpu_tx_ready", 32'(gpu_tx_ready), 32'd1);
    check("rst_link_rx_ready", 32'(link_rx_ready), 32'd1);

    // Single TX flit with one-cycle latency.
    step(1'b1, 16'h7523, 1'b1, 1'b0, 16'h0, 1'b1);
    check("tx1_data", 32'(link_tx_data), 32'h7523);
    check("tx1_valid", 32'(link_tx_valid), 32'd1);
    idle(1'b1, 1'b1);
    check("tx1_drained", 32'(tx_level), 32'd0);

    // Fill with link stalled: 8 stored, 9th dropped.
    for (int i = 0; i < 9; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b1);
    check("fill_level", 32'(tx_level), 32'(DEPTH));
    check("fill_ovf", 32'(tx_overflow), 32'd1);
    check("fill_ready", 32'(gpu_tx_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("fill_order", 32'(link_tx_data), 32'(16'h1000 + 16'(i)));
      idle(1'b1, 1'b1);
    end

    // Push on a full FIFO with a same-cycle pop is accepted.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h2ABC, 1'b1, 1'b0, 16'h0, 1'b1);
    check("full_pushpop_level", 32'(tx_level), 32'(DEPTH));
    for (int i = 0; i < 9; i++) idle(1'b1, 1'b1);

    // Matching RX flit delivered at accept+2, then three cycles not ready.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h7001, 1'b1);
    idle(1'b1, 1'b1);
    check("rx_match_valid", 32'(gpu_rx_valid), 32'd1);
    check("rx_match_data", 32'(gpu_rx_data), 32'h7001);
    repeat (3) idle(1'b1, 1'b1);

    // Back-to-back non-matching flits are both dropped.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h7401, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h7802, 1'b1);
    check("rx_drop_ready", 32'(link_rx_ready), 32'd1);
    idle(1'b1, 1'b1);

    // Held delivery while the GPU is not ready.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h7055, 1'b0);
    repeat (10) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check("rx_hold_valid", 32'(gpu_rx_valid), 32'd1);
    repeat (3) idle(1'b1, 1'b1);

    // Reset while a flit waits: it is never delivered.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h70AA, 1'b0);
    idle(1'b1, 1'b0);
    do_reset();
    repeat (4) begin
      idle(1'b1, 1'b1);
      check("rst_discard", 32'(gpu_rx_valid), 32'd0);
    end

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rd;
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd[15:10] = 6'(LOCAL);
      if (i == 300) do_reset();
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
